// File: rtl/sid_pipe_sched_pkg.sv
// Shared constants and types for the SID voice/filter pipeline scheduler.
package sid_pipe_sched_pkg;

  localparam int VOICE_LAT     = 1;
  localparam int FILTER_STAGES = 7;
  localparam int MAX_SIDS      = 4;
  localparam int SID_W         = 2;

  typedef struct packed {
    logic             valid;
    logic [SID_W-1:0] sid;
    logic [1:0]       no;
  } voice_tag_t;

  // All scheduler outputs, sized for MAX_SIDS so the datapath glue can route one bundle.
  typedef struct packed {
    logic             busy;
    logic             voice_issue;
    logic [SID_W-1:0] voice_sid;
    logic [1:0]       voice_no;
    logic             voice_cap;
    logic [SID_W-1:0] cap_sid;
    logic [1:0]       cap_no;
    logic             osc3_cap;
    logic             filter_load;
    logic [SID_W-1:0] filter_sid;
    logic [2:0]       filter_stage;
    logic             filter_done;
    logic             frame_done;
    logic             overrun;
  } sched_o_t;

endpackage

// File: rtl/sid_pipe_sched.sv
// Frame scheduler: time-multiplexes the shared voice pipeline over every voice,
// then the shared filter pipeline once per SID, with fully registered strobes.
module sid_pipe_sched
  import sid_pipe_sched_pkg::*;
#(
  parameter int NUM_SIDS = 2,
  parameter int SW       = (NUM_SIDS > 1) ? $clog2(NUM_SIDS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          voice_issue,
  output logic [SW-1:0] voice_sid,
  output logic [1:0]    voice_no,
  output logic          voice_cap,
  output logic [SW-1:0] cap_sid,
  output logic [1:0]    cap_no,
  output logic          osc3_cap,
  output logic          filter_load,
  output logic [SW-1:0] filter_sid,
  output logic [2:0]    filter_stage,
  output logic          filter_done,
  output logic          frame_done,
  output logic          overrun
);

  localparam int               KW       = $clog2(NUM_SIDS + 1);
  localparam logic [KW-1:0]    K_END    = KW'(NUM_SIDS);
  localparam logic [SID_W-1:0] LAST_SID = SID_W'(NUM_SIDS - 1);
  localparam logic [2:0]       LAST_STG = 3'(FILTER_STAGES);

  sched_o_t         so_q, so_d;
  logic [KW-1:0]    vk_q, vk_d;
  logic [1:0]       vv_q, vv_d;
  logic [SID_W-1:0] fsid_q, fsid_d;
  logic [2:0]       fstg_q, fstg_d;
  voice_tag_t       issue_tag, cap_tag_d;
  logic             accept, first_load, chain_load;

  assign issue_tag = '{valid: so_q.voice_issue, sid: so_q.voice_sid, no: so_q.voice_no};

  // cap_tag_d is the tag that becomes visible on the capture outputs next cycle.
  generate
    if (VOICE_LAT == 1) begin : g_cap_direct
      assign cap_tag_d = issue_tag;
    end else begin : g_cap_dly
      voice_tag_t dly_q [VOICE_LAT-1];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < VOICE_LAT - 1; i++) dly_q[i] <= '0;
        end else begin
          dly_q[0] <= issue_tag;
          for (int i = 1; i < VOICE_LAT - 1; i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign cap_tag_d = dly_q[VOICE_LAT-2];
    end
  endgenerate

  always_comb begin
    so_d       = '0;
    vk_d       = vk_q;
    vv_d       = vv_q;
    fsid_d     = fsid_q;
    fstg_d     = fstg_q;
    accept     = start && !so_q.busy;
    first_load = 1'b0;
    chain_load = 1'b0;

    so_d.busy    = accept || (so_q.busy && !so_q.frame_done);
    so_d.overrun = so_q.overrun || (start && so_q.busy);

    // Voice counter walks SID-major; vk == K_END means all voices issued.
    if (accept) begin
      vk_d = '0;
      vv_d = '0;
    end else if (so_q.busy && vk_q != K_END) begin
      if (vv_q == 2'd2) begin
        vv_d = '0;
        vk_d = vk_q + KW'(1);
      end else begin
        vv_d = vv_q + 2'd1;
      end
    end
    if (so_d.busy && vk_d != K_END) begin
      so_d.voice_issue = 1'b1;
      so_d.voice_sid   = SID_W'(vk_d);
      so_d.voice_no    = vv_d;
    end

    if (cap_tag_d.valid) begin
      so_d.voice_cap = 1'b1;
      so_d.cap_sid   = cap_tag_d.sid;
      so_d.cap_no    = cap_tag_d.no;
      so_d.osc3_cap  = (cap_tag_d.no == 2'd2);
    end

    // Filter counter: stage 0 idle, otherwise 1..7 rolling straight into the next SID.
    if (so_q.filter_load && fstg_q == 3'd0) begin
      fstg_d = 3'd1;
      fsid_d = so_q.filter_sid;
    end else if (fstg_q == LAST_STG) begin
      if (fsid_q == LAST_SID) begin
        fstg_d = 3'd0;
      end else begin
        fstg_d = 3'd1;
        fsid_d = fsid_q + SID_W'(1);
      end
    end else if (fstg_q != 3'd0) begin
      fstg_d = fstg_q + 3'd1;
    end

    first_load        = cap_tag_d.valid && cap_tag_d.sid == '0 && cap_tag_d.no == 2'd2;
    chain_load        = (fstg_d == LAST_STG) && (fsid_d != LAST_SID);
    so_d.filter_stage = fstg_d;
    so_d.filter_load  = first_load || chain_load;
    so_d.filter_done  = (fstg_q == LAST_STG);
    so_d.frame_done   = (fstg_q == LAST_STG) && (fsid_q == LAST_SID);

    // filter_sid names the SID a load or write-back strobe acts on; otherwise the stage owner.
    if (first_load)            so_d.filter_sid = '0;
    else if (chain_load)       so_d.filter_sid = fsid_d + SID_W'(1);
    else if (so_d.filter_done) so_d.filter_sid = fsid_q;
    else if (fstg_d != 3'd0)   so_d.filter_sid = fsid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      so_q   <= '0;
      vk_q   <= '0;
      vv_q   <= '0;
      fsid_q <= '0;
      fstg_q <= '0;
    end else begin
      so_q   <= so_d;
      vk_q   <= vk_d;
      vv_q   <= vv_d;
      fsid_q <= fsid_d;
      fstg_q <= fstg_d;
    end
  end

  assign busy         = so_q.busy;
  assign voice_issue  = so_q.voice_issue;
  assign voice_sid    = so_q.voice_sid[SW-1:0];
  assign voice_no     = so_q.voice_no;
  assign voice_cap    = so_q.voice_cap;
  assign cap_sid      = so_q.cap_sid[SW-1:0];
  assign cap_no       = so_q.cap_no;
  assign osc3_cap     = so_q.osc3_cap;
  assign filter_load  = so_q.filter_load;
  assign filter_sid   = so_q.filter_sid[SW-1:0];
  assign filter_stage = so_q.filter_stage;
  assign filter_done  = so_q.filter_done;
  assign frame_done   = so_q.frame_done;
  assign overrun      = so_q.overrun;

  // Upper SID bits are always zero when SW < SID_W.
  logic sid_hi_unused;
  assign sid_hi_unused = ^{so_q.voice_sid, so_q.cap_sid, so_q.filter_sid};

endmodule

// File: tb/tb_sid_pipe_sched.sv
// Bench for sid_pipe_sched: N=1/2/4 instances checked every cycle against a
// closed-form schedule model, plus a vector table and directed corner cases.
module tb_sid_pipe_sched;

  typedef struct packed {
    logic       issue;
    logic [1:0] vsid;
    logic [1:0] vno;
    logic       cap;
    logic [1:0] csid;
    logic [1:0] cno;
    logic       osc3;
    logic       load;
    logic [1:0] fsid;
    logic [2:0] stage;
    logic       done;
    logic       fdone;
    logic       busy;
    logic       overrun;
  } port_vec_t;

  typedef struct {
    int        cyc;
    port_vec_t v;
  } row_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  int   cyc;
  int   n_tests;
  int   n_fail;

  always #5 clk = ~clk;

  // ---- DUT N=1 ----
  logic       a_busy, a_vi, a_vc, a_osc3, a_fl, a_fd, a_frd, a_ovr;
  logic [0:0] a_vsid, a_csid, a_fsid;
  logic [1:0] a_vno, a_cno;
  logic [2:0] a_fstg;
  sid_pipe_sched #(.NUM_SIDS(1)) u_n1 (
    .clk(clk), .rst(rst), .start(start), .busy(a_busy),
    .voice_issue(a_vi), .voice_sid(a_vsid), .voice_no(a_vno),
    .voice_cap(a_vc), .cap_sid(a_csid), .cap_no(a_cno), .osc3_cap(a_osc3),
    .filter_load(a_fl), .filter_sid(a_fsid), .filter_stage(a_fstg),
    .filter_done(a_fd), .frame_done(a_frd), .overrun(a_ovr)
  );

  // ---- DUT N=2 ----
  logic       b_busy, b_vi, b_vc, b_osc3, b_fl, b_fd, b_frd, b_ovr;
  logic [0:0] b_vsid, b_csid, b_fsid;
  logic [1:0] b_vno, b_cno;
  logic [2:0] b_fstg;
  sid_pipe_sched #(.NUM_SIDS(2)) u_n2 (
    .clk(clk), .rst(rst), .start(start), .busy(b_busy),
    .voice_issue(b_vi), .voice_sid(b_vsid), .voice_no(b_vno),
    .voice_cap(b_vc), .cap_sid(b_csid), .cap_no(b_cno), .osc3_cap(b_osc3),
    .filter_load(b_fl), .filter_sid(b_fsid), .filter_stage(b_fstg),
    .filter_done(b_fd), .frame_done(b_frd), .overrun(b_ovr)
  );

  // ---- DUT N=4 ----
  logic       c_busy, c_vi, c_vc, c_osc3, c_fl, c_fd, c_frd, c_ovr;
  logic [1:0] c_vsid, c_csid, c_fsid;
  logic [1:0] c_vno, c_cno;
  logic [2:0] c_fstg;
  sid_pipe_sched #(.NUM_SIDS(4)) u_n4 (
    .clk(clk), .rst(rst), .start(start), .busy(c_busy),
    .voice_issue(c_vi), .voice_sid(c_vsid), .voice_no(c_vno),
    .voice_cap(c_vc), .cap_sid(c_csid), .cap_no(c_cno), .osc3_cap(c_osc3),
    .filter_load(c_fl), .filter_sid(c_fsid), .filter_stage(c_fstg),
    .filter_done(c_fd), .frame_done(c_frd), .overrun(c_ovr)
  );

  port_vec_t act [3];
  assign act[0] = {a_vi, 2'(a_vsid), a_vno, a_vc, 2'(a_csid), a_cno, a_osc3,
                   a_fl, 2'(a_fsid), a_fstg, a_fd, a_frd, a_busy, a_ovr};
  assign act[1] = {b_vi, 2'(b_vsid), b_vno, b_vc, 2'(b_csid), b_cno, b_osc3,
                   b_fl, 2'(b_fsid), b_fstg, b_fd, b_frd, b_busy, b_ovr};
  assign act[2] = {c_vi, c_vsid, c_vno, c_vc, c_csid, c_cno, c_osc3,
                   c_fl, c_fsid, c_fstg, c_fd, c_frd, c_busy, c_ovr};

  // ---- reference model: frame origin t0 per instance, outputs from arithmetic on r = x - t0 ----
  int nsid [3] = '{1, 2, 4};
  bit m_act [3];
  int m_t0  [3];
  bit m_ovr [3];

  function automatic bit m_busy(int i, int x);
    return m_act[i] && x >= m_t0[i] && x <= m_t0[i] + 7 * nsid[i] + 4;
  endfunction

  function automatic port_vec_t model_out(int i, int x);
    port_vec_t v;
    int n, r, lsid, dsid;
    bit ld, dn;
    v = '0;
    v.overrun = m_ovr[i];
    if (!m_busy(i, x)) return v;
    n = nsid[i];
    r = x - m_t0[i];
    v.busy = 1'b1;
    if (r < 3 * n) begin
      v.issue = 1'b1; v.vsid = 2'(r / 3); v.vno = 2'(r % 3);
    end
    if (r >= 1 && r <= 3 * n) begin
      v.cap = 1'b1; v.csid = 2'((r - 1) / 3); v.cno = 2'((r - 1) % 3);
      v.osc3 = ((r - 1) % 3 == 2);
    end
    ld = (r >= 3) && ((r - 3) % 7 == 0) && ((r - 3) / 7 < n);
    lsid = (r - 3) / 7;
    dn = (r >= 11) && ((r - 11) % 7 == 0);
    dsid = (r - 11) / 7;
    v.load = ld;
    v.done = dn;
    v.fdone = (r == 7 * n + 4);
    if (r >= 4 && r <= 7 * n + 3) v.stage = 3'(((r - 4) % 7) + 1);
    if (ld)                 v.fsid = 2'(lsid);
    else if (dn)            v.fsid = 2'(dsid);
    else if (v.stage != 0)  v.fsid = 2'((r - 4) / 7);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  row_t tbl [12];

  task automatic check_table();
    for (int i = 0; i < 12; i++)
      if (tbl[i].cyc == cyc) chk($sformatf("tbl_c%0d", cyc), 32'(act[1]), 32'(tbl[i].v));
  endtask

  task automatic check_directed();
    case (cyc)
      22:  chk("n1_frame_done", 32'(act[0].fdone), 1);
      35:  chk("n4_load_sid3", {29'd0, act[2].load, act[2].fsid}, 3'b111);
      42:  chk("n4_no_early_fdone", 32'(act[2].fdone), 0);
      43:  chk("n4_frame_done", 32'(act[2].fdone), 1);
      70:  chk("ovr_clear_before", 32'(act[1].overrun), 0);
      71:  chk("ovr_set", 32'(act[1].overrun), 1);
      79:  chk("ovr_sched_intact", {30'd0, act[1].fdone, act[1].busy}, 2'b11);
      80:  chk("idle_after_fdone", 32'(act[1].busy), 0);
      81:  chk("restart_issue_ovr", {30'd0, act[1].issue, act[1].overrun}, 2'b11);
      109: chk("rst_all_zero", 32'(act[1]), 0);
      112: chk("rst_no_done_a", 32'(act[1].done), 0);
      119: chk("rst_no_done_b", {30'd0, act[1].done, act[1].fdone}, 0);
      131: chk("post_rst_issue", {29'd0, act[1].issue, act[1].vsid}, 3'b100);
      151: chk("rst_beats_start", 32'(act[1].busy), 0);
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_act[i] = 1'b0;
        m_ovr[i] = 1'b0;
      end else if (start) begin
        if (m_busy(i, cyc)) m_ovr[i] = 1'b1;
        else begin
          m_act[i] = 1'b1;
          m_t0[i]  = cyc + 1;
        end
      end
    end
    cyc++;
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("model_n%0d", nsid[i]), 32'(act[i]), 32'(model_out(i, cyc)));
    check_table();
    check_directed();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    for (int i = 0; i < 3; i++) begin
      m_act[i] = 1'b0; m_t0[i] = 0; m_ovr[i] = 1'b0;
    end
    // N=2 frame accepted at cycle 10: issue, capture, oscillator and filter strobes
    //                  iss vs vn cap cs cn o3 ld fs stg dn fd bsy ovr
    tbl[0]  = '{10, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
    tbl[1]  = '{11, '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0}};
    tbl[2]  = '{12, '{1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0}};
    tbl[3]  = '{14, '{1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 0, 0, 1, 0}};
    tbl[4]  = '{15, '{1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0}};
    tbl[5]  = '{17, '{0, 0, 0, 1, 1, 2, 1, 0, 0, 3, 0, 0, 1, 0}};
    tbl[6]  = '{18, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 1, 0}};
    tbl[7]  = '{21, '{0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 0, 0, 1, 0}};
    tbl[8]  = '{22, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0}};
    tbl[9]  = '{28, '{0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 1, 0}};
    tbl[10] = '{29, '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0}};
    tbl[11] = '{30, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};

    // Directed: single frame, overrun, mid-frame reset, reset with start.
    for (int c = 0; c < 170; c++) begin
      rst   = (c < 3) || (c == 50) || (c == 108) || (c == 150);
      start = (c == 10) || (c == 60) || (c == 70) || (c == 80) ||
              (c == 100) || (c == 130) || (c == 150);
      tick();
    end

    // Random start spacing (dense enough to overrun) with occasional resets.
    for (int c = 0; c < 2000; c++) begin
      rst   = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 14) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
